seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment encoder. It watches a multiplexed 4-digit display bus and decodes what is being shown.
- Inputs are the active-low anode enables and active-low cathodes (bit0=a … bit6=g, bit7=dp).
- It qualifies stable scan slots, decodes each cathode pattern back to a 4-bit hex nibble, and reassembles all four digits into a register.
- Used for on-board loopback self-check of the display path and for readback by the testbench.

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_cat_decode.sv | 20 ++
 rtl/seg7_scan_decoder.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes, scan FSM states and cathode-to-hex lookup
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h27;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

    // Returns {legal, nibble}; illegal patterns (including blank) return 5'h00.
    function automatic logic [4:0] seg7_to_hex(input logic [6:0] cat);
        logic [4:0] r;
        case (cat)
            SEG_0:   r = 5'h10;
            SEG_1:   r = 5'h11;
            SEG_2:   r = 5'h12;
            SEG_3:   r = 5'h13;
            SEG_4:   r = 5'h14;
            SEG_5:   r = 5'h15;
            SEG_6:   r = 5'h16;
            SEG_7:   r = 5'h17;
            SEG_8:   r = 5'h18;
            SEG_9:   r = 5'h19;
            SEG_A:   r = 5'h1A;
            SEG_B:   r = 5'h1B;
            SEG_C:   r = 5'h1C;
            SEG_D:   r = 5'h1D;
            SEG_E:   r = 5'h1E;
            SEG_F:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_cat_decode.sv
// rtl/seg7_cat_decode.sv - combinational cathode pattern to {legal, blank, nibble}
module seg7_cat_decode
    import seg7_pkg::*;
(
    input  logic [6:0] cat,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    logic [4:0] dec;

    always_comb begin
        dec    = seg7_to_hex(cat);
        legal  = dec[4];
        nibble = dec[3:0];
        blank  = (cat == SEG_BLANK);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - qualifies scanned 7-segment slots and reassembles the 4-digit value
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  seg_an,
    input  logic [7:0]  seg_cat,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic [3:0]  dig_valid,
    output logic        frame_valid,
    output logic        err
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][3:0] an_sync;
    logic [SYNC_STAGES-1:0][7:0] cat_sync;
    logic [3:0]  s_an, prev_an;
    logic [7:0]  s_cat, prev_cat;
    logic [7:0]  cnt;
    scan_state_t state, state_next;
    logic        changed, bus_idle, capture;
    logic [3:0]  slot_sel;
    logic        one_hot, dec_legal, dec_blank, dec_ok;
    logic        accept, err_hit, frame_done;
    logic [3:0]  dec_nibble, upd, upd_acc;

    assign s_an     = an_sync[SYNC_STAGES-1];
    assign s_cat    = cat_sync[SYNC_STAGES-1];
    assign changed  = ({s_an, s_cat} != {prev_an, prev_cat});
    assign bus_idle = (s_an == 4'hF);

    // Sync and history reset to the idle bus level so reset never looks like an all-anodes-on scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_sync  <= '1;
            cat_sync <= '1;
            prev_an  <= 4'hF;
            prev_cat <= 8'hFF;
            cnt      <= 8'd0;
        end else if (clear) begin
            an_sync  <= '1;
            cat_sync <= '1;
            prev_an  <= 4'hF;
            prev_cat <= 8'hFF;
            cnt      <= 8'd0;
        end else begin
            an_sync  <= {an_sync[SYNC_STAGES-2:0], seg_an};
            cat_sync <= {cat_sync[SYNC_STAGES-2:0], seg_cat};
            prev_an  <= s_an;
            prev_cat <= s_cat;
            if (changed) begin
                cnt <= 8'd1;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!bus_idle) state_next = QUAL;
            QUAL: begin
                if (bus_idle) begin
                    state_next = IDLE;
                end else if (!changed && (cnt == CNT_MAX)) begin
                    state_next = HOLD;
                end
            end
            HOLD: if (changed) state_next = bus_idle ? IDLE : QUAL;
            default: state_next = IDLE;
        endcase
    end

    // A change on the capture cycle means the dwell just ended, so it must not be sampled.
    always_comb begin
        capture = (state == QUAL) && !bus_idle && !changed && (cnt == CNT_MAX);
    end

    seg7_cat_decode u_dec (
        .cat    (s_cat[6:0]),
        .legal  (dec_legal),
        .blank  (dec_blank),
        .nibble (dec_nibble)
    );

    always_comb begin
        slot_sel = 4'h0;
        for (int i = 0; i < 4; i++) begin
            slot_sel[i] = (s_an == ~(4'b0001 << i));
        end
    end

    assign one_hot    = |slot_sel;
    assign dec_ok     = dec_legal || dec_blank;
    assign accept     = capture && one_hot && dec_ok;
    assign err_hit    = capture && !(one_hot && dec_ok);
    assign upd_acc    = accept ? (upd | slot_sel) : upd;
    assign frame_done = accept && (upd_acc == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= 16'h0;
            dp          <= 4'h0;
            blank       <= 4'h0;
            dig_valid   <= 4'h0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            upd         <= 4'h0;
        end else if (clear) begin
            digits      <= 16'h0;
            dp          <= 4'h0;
            blank       <= 4'h0;
            dig_valid   <= 4'h0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            upd         <= 4'h0;
        end else begin
            frame_valid <= frame_done;
            upd         <= frame_done ? 4'h0 : upd_acc;
            if (err_hit) begin
                err <= 1'b1;
            end
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (slot_sel[i]) begin
                        dig_valid[i] <= 1'b1;
                        blank[i]     <= dec_blank;
                        if (dec_legal) begin
                            digits[4*i +: 4] <= dec_nibble;
                            dp[i]            <= ~s_cat[7];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed and random checks against a dwell-window model
module tb_seg7_scan_decoder;

    localparam int SC = 4;
    localparam int SS = 2;
    localparam int HD = SS + SC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  seg_an = 4'hF;
    logic [7:0]  seg_cat = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp, blank, dig_valid;
    logic        frame_valid, err;

    seg7_scan_decoder #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_an      (seg_an),
        .seg_cat     (seg_cat),
        .clear       (clear),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .dig_valid   (dig_valid),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fv_count = 0;
    int fv_base;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    // Model: history of raw samples; a slot is taken when the sample seen SS cycles ago closes
    // a run of SC+1 identical samples that the sample before it did not belong to.
    logic [11:0] hist [HD];
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_blank, m_valid, m_upd;
    logic        m_fv, m_err;
    logic [11:0] cand;
    logic        fresh;

    function automatic void model_reset();
        for (int j = 0; j < HD; j++) hist[j] = 12'hFFF;
        m_digits = 16'h0;
        m_dp = 4'h0;
        m_blank = 4'h0;
        m_valid = 4'h0;
        m_upd = 4'h0;
        m_fv = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void model_mark(input int idx);
        m_upd[idx] = 1'b1;
        if (m_upd == 4'hF) begin
            m_fv = 1'b1;
            m_upd = 4'h0;
        end
    endfunction

    function automatic void model_capture(input logic [11:0] v);
        int zeros;
        int idx;
        int code;
        zeros = 0;
        idx = 0;
        code = -1;
        for (int i = 0; i < 4; i++) begin
            if (!v[8+i]) begin
                zeros++;
                idx = i;
            end
        end
        for (int c = 0; c < 16; c++) if (seg_tab[c] == v[6:0]) code = c;
        if (zeros != 1) begin
            m_err = 1'b1;
        end else if (code >= 0) begin
            m_digits[4*idx +: 4] = 4'(code);
            m_dp[idx] = ~v[7];
            m_blank[idx] = 1'b0;
            m_valid[idx] = 1'b1;
            model_mark(idx);
        end else if (v[6:0] == 7'h7F) begin
            m_blank[idx] = 1'b1;
            m_valid[idx] = 1'b1;
            model_mark(idx);
        end else begin
            m_err = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            m_fv = 1'b0;
            cand = hist[SS-1];
            fresh = (cand[11:8] != 4'hF) && (hist[SS+SC] != cand);
            for (int j = SS; j <= SS - 1 + SC; j++) if (hist[j] != cand) fresh = 1'b0;
            if (fresh) model_capture(cand);
            for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {seg_an, seg_cat};
        end
    end

    always @(negedge clk) begin
        if (frame_valid) fv_count++;
        n_cmp++;
        if ({digits, dp, blank, dig_valid, frame_valid, err} !==
            {m_digits, m_dp, m_blank, m_valid, m_fv, m_err}) begin
            n_bad++;
            $display("FAIL scoreboard t=%0t: got dig=%h dp=%h bl=%h v=%h fv=%b err=%b, want dig=%h dp=%h bl=%h v=%h fv=%b err=%b",
                     $time, digits, dp, blank, dig_valid, frame_valid, err,
                     m_digits, m_dp, m_blank, m_valid, m_fv, m_err);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] cat, input int n);
        seg_an = an;
        seg_cat = cat;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_state", {digits, dp, blank, dig_valid, frame_valid, err}, 32'h0);

        // Full frame scan
        fv_base = fv_count;
        hold(4'hE, 8'hC0, 8);
        hold(4'hD, 8'hF9, 8);
        hold(4'hB, 8'hA4, 8);
        hold(4'h7, 8'hB0, 8);
        hold(4'hF, 8'hFF, 4);
        check("frame_digits", digits, 32'h3210);
        check("frame_valid_mask", dig_valid, 32'hF);
        check("frame_pulses", fv_count - fv_base, 32'd1);
        check("frame_err", err, 32'h0);

        // Letter with dp, exact latency
        pulse_clear();
        hold(4'hB, 8'h0E, 6);
        check("letter_not_yet", digits[11:8], 32'h0);
        hold(4'hB, 8'h0E, 1);
        check("letter_digit", digits[11:8], 32'hF);
        check("letter_dp", dp[2], 32'h1);

        // Glitch shorter than the dwell
        hold(4'hE, 8'h80, 3);
        hold(4'hE, 8'hF9, 4);
        check("glitch_no_8", digits[3:0], 32'h0);
        hold(4'hE, 8'hF9, 5);
        check("glitch_then_1", digits[3:0], 32'h1);

        // Blank, illegal pattern, ghosting anodes
        hold(4'hE, 8'hFF, 8);
        check("blank_flag", blank[0], 32'h1);
        check("blank_no_err", err, 32'h0);
        hold(4'hE, 8'h55, 8);
        check("illegal_err", err, 32'h1);
        check("illegal_keeps_digit", digits[3:0], 32'h1);
        pulse_clear();
        hold(4'hC, 8'hC0, 8);
        check("ghost_err", err, 32'h1);
        check("ghost_no_valid", dig_valid, 32'h0);
        pulse_clear();
        check("clear_err", err, 32'h0);
        check("clear_valid", dig_valid, 32'h0);

        // Clear coinciding with the frame-completing capture
        fv_base = fv_count;
        hold(4'hE, 8'hC0, 8);
        hold(4'hD, 8'hF9, 8);
        hold(4'hB, 8'hA4, 8);
        hold(4'h7, 8'hB0, 6);
        clear = 1'b1;
        hold(4'h7, 8'hB0, 1);
        clear = 1'b0;
        check("simul_flags", {digits, dp, blank, dig_valid, frame_valid, err}, 32'h0);
        check("simul_no_pulse", fv_count - fv_base, 32'd0);
        hold(4'h7, 8'hB0, 8);

        // Asynchronous reset in the middle of a dwell
        hold(4'hE, 8'hC0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {digits, dp, blank, dig_valid, frame_valid, err}, 32'h0);
        #2;
        rst_n = 1'b1;
        hold(4'hE, 8'hC0, 6);
        check("post_reset_wait", dig_valid, 32'h0);
        hold(4'hE, 8'hC0, 1);
        check("post_reset_capture", dig_valid, 32'h1);

        // Random scans
        for (int d = 0; d < 400; d++) begin
            int r;
            logic [3:0] an;
            logic [7:0] cat;
            r = $urandom_range(0, 9);
            if (r <= 6) an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) an = 4'hF;
            else an = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 6) cat = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
            else if (r == 7) cat = {1'($urandom), 7'h7F};
            else cat = 8'($urandom);
            if ($urandom_range(0, 29) == 0) pulse_clear();
            hold(an, cat, $urandom_range(1, 9));
        end
        hold(4'hF, 8'hFF, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
